// File: rtl/typedefs_pkg.sv
// Shared types for the RV32I core: ALU operation codes, controller states,
// opcode constants and the instruction-class decode used by the sequencer.
package typedefs_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } aluop_sel_t;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } ctrl_state_t;

  typedef enum logic [3:0] {
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_OP_IMM,
    CLS_OP,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct7 pattern selecting SUB (OP) and arithmetic right shift (OP/OP-IMM)
  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SRC_IMM   = 2'd1;
  localparam logic [1:0] PC_SRC_ALU   = 2'd2;

  localparam logic [1:0] WD_SRC_ALU   = 2'd0;
  localparam logic [1:0] WD_SRC_LOAD  = 2'd1;
  localparam logic [1:0] WD_SRC_PC4   = 2'd2;
  localparam logic [1:0] WD_SRC_IMM   = 2'd3;

  function automatic instr_class_t classify(input logic [6:0] opc);
    case (opc)
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_OP_IMM: return CLS_OP_IMM;
      OPC_OP:     return CLS_OP;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps opcode/funct3/funct7 onto the ALU operation. Address, link and
// upper-immediate classes all use ADD; branches use the compare operation.
module alu_decoder
  import typedefs_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output aluop_sel_t alu_sel
);

  logic alt;
  assign alt = (funct7 == F7_ALT);

  always_comb begin
    alu_sel = ALU_ADD;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (funct3)
          3'b000:  alu_sel = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_sel = ALU_SLL;
          3'b010:  alu_sel = ALU_SLT;
          3'b011:  alu_sel = ALU_SLTU;
          3'b100:  alu_sel = ALU_XOR;
          3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_sel = ALU_OR;
          default: alu_sel = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        // BEQ/BNE compare by subtraction, the ordered branches by set-less-than
        case (funct3[2:1])
          2'b10:   alu_sel = ALU_SLT;
          2'b11:   alu_sel = ALU_SLTU;
          default: alu_sel = ALU_SUB;
        endcase
      end
      default: alu_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK, counts retires, traps on bad opcodes.
module multicycle_ctrl
  import typedefs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        ops_equal,
  input  logic        op1_lt_op2,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_wen,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic [1:0]  pc_src,
  output logic        reg_wen,
  output logic [1:0]  reg_wdata_src,
  output aluop_sel_t  alu_sel,
  output logic        alu_src1,
  output logic        alu_src2,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [2:0]  dbg_state
);

  // Memory handshake: a req is a level held stable (with dmem_wen) until
  // ready is sampled high at a rising edge; that edge completes the access.
  // Ready while the matching req is low has no effect.

  ctrl_state_t  state, state_nxt;
  instr_class_t cls;
  aluop_sel_t   dec_alu;
  logic [31:0]  instret_q;
  logic         illegal_q;
  logic         branch_taken;
  logic         retire;
  logic         alu_drive;
  logic         imem_req_raw, dmem_req_raw, dmem_wen_raw;
  logic         ir_wen_raw, pc_wen_raw, reg_wen_raw;

  assign cls = classify(opcode);

  alu_decoder u_alu_decoder (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .alu_sel (dec_alu)
  );

  always_comb begin
    case (funct3)
      3'b000:         branch_taken = ops_equal;
      3'b001:         branch_taken = ~ops_equal;
      3'b100, 3'b110: branch_taken = op1_lt_op2;
      3'b101, 3'b111: branch_taken = ~op1_lt_op2;
      default:        branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (retire) instret_q <= instret_q + 32'd1;
      if (state_nxt == TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    imem_req_raw  = 1'b0;
    dmem_req_raw  = 1'b0;
    dmem_wen_raw  = 1'b0;
    ir_wen_raw    = 1'b0;
    pc_wen_raw    = 1'b0;
    reg_wen_raw   = 1'b0;
    pc_src        = PC_SRC_PLUS4;
    reg_wdata_src = WD_SRC_ALU;
    alu_drive     = 1'b0;
    retire        = 1'b0;
    case (state)
      FETCH: begin
        imem_req_raw = 1'b1;
        if (imem_ready) begin
          ir_wen_raw = 1'b1;
          state_nxt  = DECODE;
        end
      end
      DECODE: begin
        case (cls)
          CLS_ILLEGAL: state_nxt = TRAP;
          CLS_LUI:     state_nxt = WRITEBACK;
          default:     state_nxt = EXECUTE;
        endcase
      end
      EXECUTE: begin
        alu_drive = 1'b1;
        if (cls == CLS_LOAD || cls == CLS_STORE) begin
          state_nxt = MEM;
        end else if (cls == CLS_BRANCH) begin
          pc_wen_raw = 1'b1;
          pc_src     = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
          retire     = 1'b1;
          state_nxt  = FETCH;
        end else begin
          state_nxt = WRITEBACK;
        end
      end
      MEM: begin
        // ALU stays on the address computation for the whole access
        alu_drive    = 1'b1;
        dmem_req_raw = 1'b1;
        dmem_wen_raw = (cls == CLS_STORE);
        if (dmem_ready) begin
          if (cls == CLS_STORE) begin
            pc_wen_raw = 1'b1;
            retire     = 1'b1;
            state_nxt  = FETCH;
          end else begin
            state_nxt = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        alu_drive   = (cls != CLS_LUI);
        reg_wen_raw = 1'b1;
        pc_wen_raw  = 1'b1;
        retire      = 1'b1;
        state_nxt   = FETCH;
        case (cls)
          CLS_JAL: begin
            pc_src        = PC_SRC_IMM;
            reg_wdata_src = WD_SRC_PC4;
          end
          CLS_JALR: begin
            pc_src        = PC_SRC_ALU;
            reg_wdata_src = WD_SRC_PC4;
          end
          CLS_LOAD: reg_wdata_src = WD_SRC_LOAD;
          CLS_LUI:  reg_wdata_src = WD_SRC_IMM;
          default:  reg_wdata_src = WD_SRC_ALU;
        endcase
      end
      TRAP: state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  // Reset gates every strobe combinationally so an access is dropped at once
  assign imem_req = rst_n & imem_req_raw;
  assign dmem_req = rst_n & dmem_req_raw;
  assign dmem_wen = rst_n & dmem_wen_raw;
  assign ir_wen   = rst_n & ir_wen_raw;
  assign pc_wen   = rst_n & pc_wen_raw;
  assign reg_wen  = rst_n & reg_wen_raw;

  assign alu_sel  = alu_drive ? dec_alu : ALU_ADD;
  assign alu_src1 = alu_drive & (cls == CLS_AUIPC || cls == CLS_JAL);
  assign alu_src2 = alu_drive & ~(cls == CLS_OP || cls == CLS_BRANCH);

  assign illegal   = illegal_q;
  assign instret   = instret_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a table of zero-wait instructions plus
// hand-written wait-state, trap, reset and counter-wrap sequences.
module tb_multicycle_ctrl;
  import typedefs_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        ops_equal;
  logic        op1_lt_op2;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_wen;
  logic        ir_wen;
  logic        pc_wen;
  logic [1:0]  pc_src;
  logic        reg_wen;
  logic [1:0]  reg_wdata_src;
  aluop_sel_t  alu_sel;
  logic        alu_src1;
  logic        alu_src2;
  logic        illegal;
  logic [31:0] instret;
  logic [2:0]  dbg_state;

  multicycle_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .ops_equal     (ops_equal),
    .op1_lt_op2    (op1_lt_op2),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .imem_req      (imem_req),
    .dmem_req      (dmem_req),
    .dmem_wen      (dmem_wen),
    .ir_wen        (ir_wen),
    .pc_wen        (pc_wen),
    .pc_src        (pc_src),
    .reg_wen       (reg_wen),
    .reg_wdata_src (reg_wdata_src),
    .alu_sel       (alu_sel),
    .alu_src1      (alu_src1),
    .alu_src2      (alu_src2),
    .illegal       (illegal),
    .instret       (instret),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_instret;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       eq;
    logic       lt;
    int         lat;
    logic [1:0] pc_src;
    logic       reg_wen;
    logic [1:0] wd;
    logic       chk_alu;
    aluop_sel_t alu;
    logic       src1;
    logic       src2;
    logic       st;
  } vec_t;

  typedef struct {
    int          lat;
    int          ir_cyc;
    int          dreq_cnt;
    logic [1:0]  pc_src;
    logic        reg_wen;
    logic [1:0]  wd;
    logic [3:0]  alu;
    logic        src1;
    logic        src2;
    logic        wen_seen;
    logic        overlap;
    logic [31:0] instret;
  } res_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                              logic eq, logic lt, int lat, logic [1:0] pcs,
                              logic rw, logic [1:0] wd, logic ca,
                              aluop_sel_t alu, logic s1, logic s2, logic st);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.eq = eq; v.lt = lt; v.lat = lat;
    v.pc_src = pcs; v.reg_wen = rw; v.wd = wd; v.chk_alu = ca; v.alu = alu;
    v.src1 = s1; v.src2 = s2; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // driver: runs one instruction from FETCH to its retire cycle, inserting
  // iw/dw wait cycles on the memories; returns at the negedge back in FETCH
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic eq, input logic lt,
                           input int iw, input int dw, output res_t r);
    int  icnt;
    int  dcnt;
    int  cyc;
    bit  done;
    r = '{default: '0};
    opcode = op; funct3 = f3; funct7 = f7; ops_equal = eq; op1_lt_op2 = lt;
    icnt = 0; dcnt = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      cyc++;
      if (imem_req) begin imem_ready = (icnt >= iw); icnt++; end
      else imem_ready = 1'b1;
      if (dmem_req) begin dmem_ready = (dcnt >= dw); dcnt++; end
      else dmem_ready = 1'b1;
      #1;
      if (ir_wen && r.ir_cyc == 0) r.ir_cyc = cyc;
      if (ir_wen && (pc_wen || reg_wen)) r.overlap = 1'b1;
      if (dmem_req && dmem_wen) r.wen_seen = 1'b1;
      if (r.ir_cyc != 0 && cyc == r.ir_cyc + 2) begin
        r.alu = alu_sel; r.src1 = alu_src1; r.src2 = alu_src2;
      end
      if (pc_wen) begin
        done = 1'b1; r.lat = cyc; r.pc_src = pc_src;
        r.reg_wen = reg_wen; r.wd = reg_wdata_src;
      end
      @(negedge clk);
    end
    r.dreq_cnt = dcnt;
    r.instret  = instret;
  endtask

  res_t r;

  initial begin
    //        op          f3      f7          eq lt lat pcs rw wd ca alu       s1 s2 st
    vecs[0]  = mk(7'b0010011, 3'b000, 7'b0000000, 0, 0, 4, 0, 1, 0, 1, ALU_ADD,  0, 1, 0); // ADDI
    vecs[1]  = mk(7'b0110011, 3'b000, 7'b0000000, 0, 0, 4, 0, 1, 0, 1, ALU_ADD,  0, 0, 0); // ADD
    vecs[2]  = mk(7'b0110011, 3'b000, 7'b0100000, 0, 0, 4, 0, 1, 0, 1, ALU_SUB,  0, 0, 0); // SUB
    vecs[3]  = mk(7'b0010011, 3'b101, 7'b0100000, 0, 0, 4, 0, 1, 0, 1, ALU_SRA,  0, 1, 0); // SRAI
    vecs[4]  = mk(7'b0110011, 3'b011, 7'b0000000, 0, 0, 4, 0, 1, 0, 1, ALU_SLTU, 0, 0, 0); // SLTU
    vecs[5]  = mk(7'b0010111, 3'b000, 7'b0000000, 0, 0, 4, 0, 1, 0, 1, ALU_ADD,  1, 1, 0); // AUIPC
    vecs[6]  = mk(7'b1101111, 3'b000, 7'b0000000, 0, 0, 4, 1, 1, 2, 1, ALU_ADD,  1, 1, 0); // JAL
    vecs[7]  = mk(7'b1100111, 3'b000, 7'b0000000, 0, 0, 4, 2, 1, 2, 1, ALU_ADD,  0, 1, 0); // JALR
    vecs[8]  = mk(7'b0110111, 3'b000, 7'b0000000, 0, 0, 3, 0, 1, 3, 0, ALU_ADD,  0, 0, 0); // LUI
    vecs[9]  = mk(7'b1100011, 3'b000, 7'b0000000, 1, 0, 3, 1, 0, 0, 1, ALU_SUB,  0, 0, 0); // BEQ taken
    vecs[10] = mk(7'b1100011, 3'b000, 7'b0000000, 0, 0, 3, 0, 0, 0, 1, ALU_SUB,  0, 0, 0); // BEQ not
    vecs[11] = mk(7'b1100011, 3'b001, 7'b0000000, 0, 0, 3, 1, 0, 0, 1, ALU_SUB,  0, 0, 0); // BNE taken
    vecs[12] = mk(7'b1100011, 3'b100, 7'b0000000, 0, 1, 3, 1, 0, 0, 1, ALU_SLT,  0, 0, 0); // BLT taken
    vecs[13] = mk(7'b1100011, 3'b101, 7'b0000000, 0, 1, 3, 0, 0, 0, 1, ALU_SLT,  0, 0, 0); // BGE not
    vecs[14] = mk(7'b1100011, 3'b111, 7'b0000000, 0, 0, 3, 1, 0, 0, 1, ALU_SLTU, 0, 0, 0); // BGEU taken
    vecs[15] = mk(7'b0000011, 3'b010, 7'b0000000, 0, 0, 5, 0, 1, 1, 1, ALU_ADD,  0, 1, 0); // LW
    vecs[16] = mk(7'b0100011, 3'b010, 7'b0000000, 0, 0, 4, 0, 0, 0, 1, ALU_ADD,  0, 1, 1); // SW

    rst_n = 1'b0; opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0000000;
    ops_equal = 1'b0; op1_lt_op2 = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_imem_req", 0, imem_req, 0);
    check("rst_ir_wen",   0, ir_wen, 0);
    check("rst_pc_wen",   0, pc_wen, 0);
    check("rst_reg_wen",  0, reg_wen, 0);
    check("rst_dmem_req", 0, {dmem_req, dmem_wen}, 0);
    check("rst_instret",  0, instret, 0);
    check("rst_illegal",  0, illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 0;

    for (int i = 0; i < 17; i++) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].eq, vecs[i].lt, 0, 0, r);
      exp_instret++;
      check("latency",  i, r.lat, vecs[i].lat);
      check("ir_cycle", i, r.ir_cyc, 1);
      check("pc_src",   i, r.pc_src, vecs[i].pc_src);
      check("reg_wen",  i, r.reg_wen, vecs[i].reg_wen);
      check("wd_src",   i, r.wd, vecs[i].wd);
      if (vecs[i].chk_alu) begin
        check("alu_sel",  i, r.alu, 32'(vecs[i].alu));
        check("alu_src1", i, r.src1, vecs[i].src1);
        check("alu_src2", i, r.src2, vecs[i].src2);
      end
      check("dmem_wen", i, r.wen_seen, vecs[i].st);
      check("overlap",  i, r.overlap, 0);
      check("instret",  i, r.instret, exp_instret);
    end

    // LW with two dmem wait cycles
    run_instr(7'b0000011, 3'b010, 7'b0, 0, 0, 0, 2, r);
    exp_instret++;
    check("lw_wait_lat",  100, r.lat, 7);
    check("lw_wait_dreq", 100, r.dreq_cnt, 3);
    check("lw_wait_wen",  100, r.wen_seen, 0);
    check("lw_wait_wd",   100, r.wd, 1);
    check("lw_wait_ret",  100, r.instret, exp_instret);

    // SW with one dmem wait cycle
    run_instr(7'b0100011, 3'b010, 7'b0, 0, 0, 0, 1, r);
    exp_instret++;
    check("sw_wait_lat",  101, r.lat, 5);
    check("sw_wait_dreq", 101, r.dreq_cnt, 2);
    check("sw_wait_wen",  101, r.wen_seen, 1);
    check("sw_wait_rwen", 101, r.reg_wen, 0);

    // ADDI with three imem wait cycles
    run_instr(7'b0010011, 3'b000, 7'b0, 0, 0, 3, 0, r);
    exp_instret++;
    check("fetch_wait_lat", 102, r.lat, 7);
    check("fetch_wait_ir",  102, r.ir_cyc, 4);
    check("fetch_wait_ret", 102, r.instret, exp_instret);

    // instret wrap on a store retire
    imem_ready = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    @(negedge clk);
    run_instr(7'b0100011, 3'b010, 7'b0, 0, 0, 0, 0, r);
    check("wrap_instret", 103, r.instret, 0);
    check("wrap_wen",     103, r.wen_seen, 1);
    check("wrap_lat",     103, r.lat, 4);

    // illegal opcode: trap holds until reset
    opcode = 7'b1111111; imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    check("trap_fetch_ir", 104, ir_wen, 1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      #1;
      check("trap_illegal", i, illegal, 1);
      check("trap_strobes", i, {imem_req, dmem_req, dmem_wen, ir_wen, pc_wen, reg_wen}, 0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("trap_rst_illegal", 105, illegal, 0);
    check("trap_rst_instret", 105, instret, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("trap_restart_req", 105, imem_req, 1);
    @(negedge clk);
    // the FETCH above already loaded IR; finish that (illegal) one via reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // reset in the middle of a stalled load
    opcode = 7'b0000011; funct3 = 3'b010; imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midrst_dreq_before", 106, dmem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_dreq", 106, {dmem_req, dmem_wen}, 0);
    check("midrst_wen",  106, {pc_wen, reg_wen, ir_wen}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    run_instr(7'b0010011, 3'b000, 7'b0, 0, 0, 0, 0, r);
    check("midrst_lat",     107, r.lat, 4);
    check("midrst_instret", 107, r.instret, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
